// File: rtl/dt_pkg.sv
// dt_pkg: shared types, widths and reset constant for the sequential decision-tree engine
package dt_pkg;
  localparam int DT_IN_W = 14;
  localparam int DT_OUT_W = 14;
  localparam int DT_MAX_NODES = 128;
  localparam int DT_MAX_DEPTH = 16;
  function automatic int feat_w(input int in_w);
    return $clog2(in_w);
  endfunction
  function automatic int node_aw(input int max_nodes);
    return $clog2(max_nodes);
  endfunction
  localparam int DT_FEAT_W = feat_w(DT_IN_W);
  localparam int DT_NODE_AW = node_aw(DT_MAX_NODES);
  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
  typedef struct packed {
    logic leaf;
    logic [DT_FEAT_W-1:0] feat;
    logic [DT_NODE_AW-1:0] lo;
    logic [DT_NODE_AW-1:0] hi;
    logic [DT_OUT_W-1:0] val;
  } node_t;
  localparam node_t RESET_NODE = '{leaf: 1'b1, feat: '0, lo: '0, hi: '0, val: '0};
endpackage

// File: rtl/dt_node_table.sv
// dt_node_table: register array of tree nodes with one sync write port and one comb read port
module dt_node_table
  import dt_pkg::*;
#(
  parameter int MAX_NODES = DT_MAX_NODES,
  parameter int NODE_AW = DT_NODE_AW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic [NODE_AW-1:0] waddr,
  input  node_t wnode,
  input  logic [NODE_AW-1:0] raddr,
  output node_t rnode
);
  node_t mem_q [MAX_NODES];
  always_ff @(posedge clk)
    for (int i = 0; i < MAX_NODES; i++)
      if (!rst_n) mem_q[i] <= RESET_NODE;
      else if (we && waddr == NODE_AW'(i)) mem_q[i] <= wnode;
  assign rnode = mem_q[raddr];
endmodule

// File: rtl/dt_seq_engine.sv
// dt_seq_engine: table-driven decision-tree classifier walking one node per clock
module dt_seq_engine
  import dt_pkg::*;
#(
  parameter int IN_W = DT_IN_W,
  parameter int OUT_W = DT_OUT_W,
  parameter int MAX_NODES = DT_MAX_NODES,
  parameter int MAX_DEPTH = DT_MAX_DEPTH,
  localparam int FEAT_W = feat_w(IN_W),
  localparam int NODE_AW = node_aw(MAX_NODES),
  localparam int STEP_W = $clog2(MAX_DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [IN_W-1:0] in_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [OUT_W-1:0] out_class,
  output logic out_err,
  input  logic cfg_we,
  input  logic [NODE_AW-1:0] cfg_addr,
  input  logic cfg_leaf,
  input  logic [FEAT_W-1:0] cfg_feat,
  input  logic [NODE_AW-1:0] cfg_lo,
  input  logic [NODE_AW-1:0] cfg_hi,
  input  logic [OUT_W-1:0] cfg_val,
  output logic busy
);
  state_t state_q, state_d;
  logic [IN_W-1:0] data_q, data_d;
  logic [NODE_AW-1:0] cur_q, cur_d, nxt;
  logic [STEP_W-1:0] step_q, step_d;
  logic [OUT_W-1:0] class_q, class_d;
  logic err_q, err_d, bad, walk_end, walking;
  node_t node;
  dt_node_table #(.MAX_NODES(MAX_NODES), .NODE_AW(NODE_AW)) u_table (
    .clk(clk),
    .rst_n(rst_n),
    .we(cfg_we && state_q == IDLE),
    .waddr(cfg_addr),
    .wnode('{cfg_leaf, cfg_feat, cfg_lo, cfg_hi, cfg_val}),
    .raddr(cur_q),
    .rnode(node)
  );
  always_comb begin
    walking = state_q == WALK;
    nxt = data_q[node.feat] ? node.hi : node.lo;
    bad = 32'(node.feat) >= 32'(IN_W) || 32'(nxt) >= 32'(MAX_NODES) || 32'(step_q) == 32'(MAX_DEPTH - 1);
    walk_end = node.leaf || bad;
    state_d = state_q == IDLE ? (in_valid ? WALK : IDLE) : walking ? (walk_end ? DONE : WALK) : (out_ready ? IDLE : DONE);
    data_d = state_q == IDLE && in_valid ? in_data : data_q;
    cur_d = state_q == IDLE ? '0 : walking && !walk_end ? nxt : cur_q;
    step_d = state_q == IDLE ? '0 : walking && !walk_end ? step_q + 1'b1 : step_q;
    class_d = walking && walk_end ? (node.leaf ? node.val : '0) : class_q;
    err_d = walking && walk_end ? !node.leaf : err_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      data_q <= '0;
      cur_q <= '0;
      step_q <= '0;
      class_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      cur_q <= cur_d;
      step_q <= step_d;
      class_q <= class_d;
      err_q <= err_d;
    end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign out_class = class_q;
  assign out_err = err_q;
endmodule

// File: tb/tb_dt_seq_engine.sv
// tb_dt_seq_engine: scoreboard bench with a behavioural tree-walk model
module tb_dt_seq_engine;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1, cfg_we = 0, cfg_leaf = 0;
  logic [13:0] in_data = '0, cfg_val = '0;
  logic [3:0] cfg_feat = '0;
  logic [6:0] cfg_addr = '0, cfg_lo = '0, cfg_hi = '0;
  logic in_ready, out_valid, out_err, busy;
  logic [13:0] out_class;
  dt_seq_engine dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_leaf(cfg_leaf), .cfg_feat(cfg_feat),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_val(cfg_val), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int vectors = 0, errors = 0;
  logic m_leaf [128];
  logic [3:0] m_feat [128];
  logic [6:0] m_lo [128], m_hi [128];
  logic [13:0] m_val [128];
  typedef struct {logic [13:0] cls; logic err; int at;} exp_t;
  exp_t sb[$];
  exp_t cur_e;
  bit seen = 0;
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic void model_clear();
    for (int i = 0; i < 128; i++) begin
      m_leaf[i] = 1; m_feat[i] = 0; m_lo[i] = 0; m_hi[i] = 0; m_val[i] = 0;
    end
  endfunction
  function automatic exp_t model(input logic [13:0] d, input int now);
    exp_t e;
    int cur = 0;
    e.cls = '0; e.err = 1; e.at = now + 17;
    for (int k = 0; k < 16; k++) begin
      if (m_leaf[cur]) begin
        e.cls = m_val[cur]; e.err = 0; e.at = now + k + 2;
        return e;
      end
      if (m_feat[cur] >= 14 || k == 15) begin
        e.at = now + k + 2;
        return e;
      end
      cur = d[m_feat[cur]] ? int'(m_hi[cur]) : int'(m_lo[cur]);
    end
    return e;
  endfunction
  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        if (sb.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          cur_e = sb.pop_front();
          chk("class", int'(out_class), int'(cur_e.cls));
          chk("err", int'(out_err), int'(cur_e.err));
          chk("latency", cyc, cur_e.at);
        end
      end else begin
        chk("hold_class", int'(out_class), int'(cur_e.cls));
        chk("hold_err", int'(out_err), int'(cur_e.err));
      end
      if (out_ready) seen = 0;
    end
  end
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin @(negedge clk); n++; end
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask
  task automatic set_cfg(input logic [6:0] a, input logic lf, input logic [3:0] f,
                         input logic [6:0] lo, input logic [6:0] hi, input logic [13:0] v);
    cfg_we = 1; cfg_addr = a; cfg_leaf = lf; cfg_feat = f; cfg_lo = lo; cfg_hi = hi; cfg_val = v;
    m_leaf[a] = lf; m_feat[a] = f; m_lo[a] = lo; m_hi[a] = hi; m_val[a] = v;
  endtask
  task automatic wr(input logic [6:0] a, input logic lf, input logic [3:0] f,
                    input logic [6:0] lo, input logic [6:0] hi, input logic [13:0] v);
    wait_idle();
    set_cfg(a, lf, f, lo, hi, v);
    @(posedge clk); #1 cfg_we = 0;
  endtask
  task automatic send(input logic [13:0] d, input bit busy_wr);
    wait_idle();
    in_valid = 1; in_data = d;
    sb.push_back(model(d, cyc));
    @(posedge clk); #1 in_valid = 0;
    if (busy_wr) begin
      cfg_we = 1; cfg_addr = 7'd1; cfg_leaf = 1; cfg_val = 14'($urandom);
      @(posedge clk); #1 cfg_we = 0;
    end
  endtask
  task automatic send_w(input logic [13:0] d, input logic [6:0] a, input logic lf, input logic [3:0] f,
                        input logic [6:0] lo, input logic [6:0] hi, input logic [13:0] v);
    wait_idle();
    set_cfg(a, lf, f, lo, hi, v);
    in_valid = 1; in_data = d;
    sb.push_back(model(d, cyc));
    @(posedge clk); #1 in_valid = 0; cfg_we = 0;
  endtask
  task automatic do_reset(input int n);
    rst_n = 0; in_valid = 0; cfg_we = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    sb.delete();
    model_clear();
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_class", int'(out_class), 0);
    chk("rst_err", int'(out_err), 0);
    rst_n = 1;
  endtask
  task automatic load_tree();
    wr(7'd0, 0, 4'd10, 7'd1, 7'd2, 14'h0);
    wr(7'd1, 1, 4'd0, 7'd0, 7'd0, 14'h0103);
    wr(7'd2, 0, 4'd13, 7'd3, 7'd4, 14'h0);
    wr(7'd3, 1, 4'd0, 7'd0, 7'd0, 14'h0);
    wr(7'd4, 1, 4'd0, 7'd0, 7'd0, 14'h2108);
  endtask
  initial begin
    int n;
    model_clear();
    do_reset(2);
    send(14'h0400, 0);
    load_tree();
    send(14'h0000, 0);
    send(14'h2400, 0);
    wait_idle();
    @(posedge clk); #1 out_ready = 0;
    send(14'h0000, 0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_out_valid_seen", int'(out_valid), 1);
    in_valid = 1; in_data = 14'h2400;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1 out_ready = 1; in_valid = 0;
    @(posedge clk); #1;
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_release_out_valid", int'(out_valid), 0);
    send(14'h0000, 1);
    send(14'h0000, 0);
    send(14'h2400, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    model_clear();
    rst_n = 1;
    send(14'h0000, 0);
    wr(7'd0, 0, 4'd0, 7'd0, 7'd0, 14'h0);
    send(14'(($urandom)), 0);
    wr(7'd0, 0, 4'd15, 7'd0, 7'd0, 14'h0);
    send(14'h3fff, 0);
    do_reset(1);
    for (int it = 0; it < 80; it++) begin
      int r;
      logic lf;
      logic [3:0] f;
      logic [6:0] a, lo, hi;
      r = $urandom_range(0, 9);
      a = 7'($urandom_range(0, 15));
      lf = $urandom_range(0, 9) < 4;
      f = $urandom_range(0, 9) == 0 ? 4'($urandom_range(14, 15)) : 4'($urandom_range(0, 13));
      lo = $urandom_range(0, 7) == 0 ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      hi = $urandom_range(0, 7) == 0 ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 15));
      if (r < 4) wr(a, lf, f, lo, hi, 14'($urandom));
      else if (r == 4) send_w(14'($urandom), a, lf, f, lo, hi, 14'($urandom));
      else send(14'($urandom), $urandom_range(0, 3) == 0);
    end
    n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !in_ready) && n < 500) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
